// File: rtl/alu_seq_if.sv
// -----------------------------------------------------------------------------
// alu_seq_if
// Request/response bundle between the datapath controller and alu_seq.
//
//   start   : request, accepted only while busy = 0
//   aluop   : 00 add, 01 sub, 1x R-type (funct decode)
//   funct   : R-type function code
//   a, b    : operands (b also supplies the shift amount)
//   busy    : iterative operation in progress
//   done    : one-cycle pulse when result/zero/ill are updated
//   result  : registered result, held until the next completion
//   zero    : registered (result == 0)
//   ill     : registered, last operation had an unmatched funct
//
// master : the controller side (drives the request)
// slave  : the ALU side (drives the response)
// -----------------------------------------------------------------------------
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       aluop;
    logic [3:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ill;

    modport master (
        output start, aluop, funct, a, b,
        input  busy, done, result, zero, ill
    );

    modport slave (
        input  start, aluop, funct, a, b,
        output busy, done, result, zero, ill
    );
endinterface

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Sequential ALU with built-in ALU-control decode for the multi-cycle datapath.
// Logic ops, add, sub, slt and pass-A complete on the accepting edge. Variable
// shifts move one bit position per clock; multiply is radix-2 shift-add and
// takes WIDTH clocks. Operands and opcode are captured on the accepting edge.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_seq_if.slave (start/aluop/funct/a/b in,
//           busy/done/result/zero/ill out)
//
// Parameters:
//   WIDTH  : operand/result width (>= 4, power of 2)
//   MUL_EN : 1 = multiply implemented, 0 = funct 1001 decodes as illegal
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_seq_if.slave  bus
);
    localparam int SW = $clog2(WIDTH);
    // Counter must hold WIDTH itself for multiply.
    localparam int CW = SW + 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_SLT,
        OP_PASS,
        OP_SRL,
        OP_SLL,
        OP_MUL,
        OP_ILL
    } op_t;

    state_t           state;
    op_t              op_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             ill_q;

    op_t              dec_op;
    logic [CW-1:0]    dec_n;
    logic [WIDTH-1:0] one_res;
    logic [WIDTH-1:0] acc_step;

    // ------------------------------------------------------------------
    // ALU-control decode of the live request inputs.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        dec_op = OP_ILL;
        if (!bus.aluop[1]) begin
            dec_op = bus.aluop[0] ? OP_SUB : OP_ADD;
        end else begin
            case (bus.funct)
                4'b0000: dec_op = OP_ADD;
                4'b0010: dec_op = OP_SUB;
                4'b0100: dec_op = OP_AND;
                4'b0101: dec_op = OP_OR;
                4'b1010: dec_op = OP_SLT;
                4'b0111: dec_op = OP_PASS;
                4'b0110: dec_op = OP_SRL;
                4'b1000: dec_op = OP_SLL;
                4'b1001: dec_op = MUL_EN ? OP_MUL : OP_ILL;
                default: dec_op = OP_ILL;
            endcase
        end
    end

    // Iteration count: shifts step once per bit position, multiply once per
    // multiplier bit, everything else completes immediately.
    always_comb begin
        dec_n = '0;
        case (dec_op)
            OP_SRL, OP_SLL: dec_n = {1'b0, bus.b[SW-1:0]};
            OP_MUL:         dec_n = CW'(WIDTH);
            default:        dec_n = '0;
        endcase
    end

    // Single-cycle result. A zero-length shift lands here and yields A.
    always_comb begin
        one_res = '0;
        case (dec_op)
            OP_ADD:         one_res = bus.a + bus.b;
            OP_SUB:         one_res = bus.a - bus.b;
            OP_AND:         one_res = bus.a & bus.b;
            OP_OR:          one_res = bus.a | bus.b;
            OP_SLT:         one_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            OP_PASS:        one_res = bus.a;
            OP_SRL, OP_SLL: one_res = bus.a;
            default:        one_res = '0;
        endcase
    end

    // One iteration step of the captured operation.
    always_comb begin
        acc_step = acc;
        case (op_q)
            OP_SRL:  acc_step = acc >> 1;
            OP_SLL:  acc_step = acc << 1;
            OP_MUL:  acc_step = mplier[0] ? (acc + mcand) : acc;
            default: acc_step = acc;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM and datapath registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= OP_ADD;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ill_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (dec_n == '0) begin
                            result_q <= one_res;
                            zero_q   <= (one_res == '0);
                            ill_q    <= (dec_op == OP_ILL);
                            done_q   <= 1'b1;
                        end else begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                            op_q   <= dec_op;
                            cnt    <= dec_n;
                            // Multiply accumulates from zero; shifts work on A.
                            acc    <= (dec_op == OP_MUL) ? '0 : bus.a;
                            mcand  <= bus.a;
                            mplier <= bus.b;
                        end
                    end
                end
                RUN: begin
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    // Last step: counter reaches zero on this edge.
                    if (cnt == CW'(1)) begin
                        result_q <= acc_step;
                        zero_q   <= (acc_step == '0);
                        ill_q    <= 1'b0;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.zero   = zero_q;
    assign bus.ill    = ill_q;

endmodule
